dmem_responder: RTL and testbench

- Responder (slave) end of the core's data-memory port. Holds a word-organised on-chip RAM and serves byte, half and word loads and stores.
- Read data is presented one cycle after request acceptance. Optional wait states stall the pipeline through dmem_wait.
- Sits between the core's dmem_* outputs and the core's dmem_read_data/dmem_wait inputs. Replaces the simple buffered RAM with a configurable-latency memory usable for stall verification.

---
 rtl/dmem_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory port.
// A word-organised RAM serves byte, half and word loads and stores. Every
// accepted request spends WAIT_CYCLES stall cycles, then completes in DONE,
// where the read result, the RAM write and any access fault take effect.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] dmem_address,
   input  logic        dmem_enable,
   input  logic [31:0] dmem_write_data,
   input  logic        dmem_write_enable,
   input  logic [2:0]  dmem_write_mode,
   input  logic        dmem_read_enable,
   input  logic [2:0]  dmem_read_mode,
   output logic [31:0] dmem_read_data,
   output logic        dmem_wait,
   output logic        access_fault
);

   localparam int         IDX_W     = ADDR_WIDTH - 2;
   localparam int         DEPTH     = 1 << IDX_W;
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Store modes: only byte, half and word exist.
   function automatic logic write_mode_ok(input logic [2:0] mode);
      case (mode)
         3'b000, 3'b001, 3'b010: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   // Load modes: bit 2 (unsigned hint) is accepted for byte and half only.
   function automatic logic read_mode_ok(input logic [2:0] mode);
      case (mode)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   // Natural alignment check on the low two address bits.
   function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] a);
      case (mode[1:0])
         2'b01:   return a[0];
         2'b10:   return (a != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // Byte lanes touched by a store of the given size at the given offset.
   function automatic logic [3:0] lane_mask(input logic [2:0] mode, input logic [1:0] a);
      case (mode)
         3'b000:  return 4'b0001 << a;
         3'b001:  return a[1] ? 4'b1100 : 4'b0011;
         3'b010:  return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   state_t                state_r;
   logic [3:0]            count_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [31:0]           wdata_r;
   logic [2:0]            wmode_r;
   logic [2:0]            rmode_r;
   logic                  we_r;
   logic                  re_r;
   logic [31:0]           rdata_r;
   logic                  wait_r;
   logic                  fault_r;
   logic [31:0]           mem [DEPTH];

   logic                  idle_like_s;
   logic                  accept_s;
   logic                  complete_s;
   logic [ADDR_WIDTH-1:0] req_addr_s;
   logic [31:0]           req_wdata_s;
   logic [2:0]            req_wmode_s;
   logic [2:0]            req_rmode_s;
   logic                  req_we_s;
   logic                  req_re_s;
   logic [31:0]           rd_word_s;
   logic [31:0]           byte_sh_s;
   logic [31:0]           half_sh_s;
   logic [31:0]           rd_lane_s;
   logic                  rd_fault_s;
   logic                  wr_fault_s;
   logic                  fault_s;
   logic [3:0]            mask_s;
   logic [31:0]           mask32_s;
   logic [31:0]           wr_align_s;
   logic [31:0]           merged_s;
   logic                  mem_write_s;
   logic                  unused_addr_bits_s;

   // Upper address bits alias onto the RAM and are intentionally ignored.
   assign unused_addr_bits_s = ^dmem_address[31:ADDR_WIDTH];

   assign dmem_read_data = rdata_r;
   assign dmem_wait      = wait_r;
   assign access_fault   = fault_r;

   // Pick the completing request: live inputs when accepting with no wait, else the latched copy.
   always_comb begin
      idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
      accept_s    = idle_like_s && dmem_enable && (dmem_read_enable || dmem_write_enable);
      if (idle_like_s) begin
         req_addr_s  = dmem_address[ADDR_WIDTH-1:0];
         req_wdata_s = dmem_write_data;
         req_wmode_s = dmem_write_mode;
         req_rmode_s = dmem_read_mode;
         req_we_s    = dmem_write_enable;
         req_re_s    = dmem_read_enable;
         complete_s  = accept_s && NO_WAIT;
      end else begin
         req_addr_s  = addr_r;
         req_wdata_s = wdata_r;
         req_wmode_s = wmode_r;
         req_rmode_s = rmode_r;
         req_we_s    = we_r;
         req_re_s    = re_r;
         complete_s  = (state_r == ST_WAIT) && (count_r == 4'd0);
      end
   end

   // Lane extraction, store merge and fault decode for the completing request.
   always_comb begin
      rd_word_s  = mem[req_addr_s[ADDR_WIDTH-1:2]];
      rd_fault_s = !read_mode_ok(req_rmode_s) || misaligned(req_rmode_s, req_addr_s[1:0]);
      wr_fault_s = !write_mode_ok(req_wmode_s) || misaligned(req_wmode_s, req_addr_s[1:0]);
      byte_sh_s  = rd_word_s >> {req_addr_s[1:0], 3'b000};
      half_sh_s  = rd_word_s >> {req_addr_s[1], 4'b0000};
      case (req_rmode_s[1:0])
         2'b00:   rd_lane_s = {24'd0, byte_sh_s[7:0]};
         2'b01:   rd_lane_s = {16'd0, half_sh_s[15:0]};
         2'b10:   rd_lane_s = rd_word_s;
         default: rd_lane_s = 32'd0;
      endcase
      mask_s   = lane_mask(req_wmode_s, req_addr_s[1:0]);
      mask32_s = {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}};
      case (req_wmode_s[1:0])
         2'b00:   wr_align_s = {4{req_wdata_s[7:0]}};
         2'b01:   wr_align_s = {2{req_wdata_s[15:0]}};
         default: wr_align_s = req_wdata_s;
      endcase
      merged_s    = (rd_word_s & ~mask32_s) | (wr_align_s & mask32_s);
      mem_write_s = complete_s && req_we_s && !wr_fault_s && reset_n;
      fault_s     = (req_re_s && rd_fault_s) || (req_we_s && wr_fault_s);
   end

   // RAM array: not reset, written only when a legal store completes.
   always_ff @(posedge clk) begin
      if (mem_write_s) begin
         mem[req_addr_s[ADDR_WIDTH-1:2]] <= merged_s;
      end
   end

   // Request FSM with registered wait, read data and fault outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         count_r <= 4'd0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         wmode_r <= 3'd0;
         rmode_r <= 3'd0;
         we_r    <= 1'b0;
         re_r    <= 1'b0;
         rdata_r <= 32'd0;
         wait_r  <= 1'b0;
         fault_r <= 1'b0;
      end else begin
         fault_r <= complete_s && fault_s;
         if (complete_s && req_re_s) begin
            rdata_r <= rd_fault_s ? 32'd0 : rd_lane_s;
         end
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (accept_s) begin
                  addr_r  <= dmem_address[ADDR_WIDTH-1:0];
                  wdata_r <= dmem_write_data;
                  wmode_r <= dmem_write_mode;
                  rmode_r <= dmem_read_mode;
                  we_r    <= dmem_write_enable;
                  re_r    <= dmem_read_enable;
                  if (NO_WAIT) begin
                     state_r <= ST_DONE;
                     wait_r  <= 1'b0;
                  end else begin
                     state_r <= ST_WAIT;
                     count_r <= WAIT_INIT;
                     wait_r  <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
                  wait_r  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (count_r == 4'd0) begin
                  state_r <= ST_DONE;
                  wait_r  <= 1'b0;
               end else begin
                  count_r <= count_r - 4'd1;
                  wait_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               wait_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one zero-wait and one three-wait instance, driven
// with directed and random requests and compared against a byte-level
// memory model.
module tb_dmem_responder;

   logic        clk;
   logic        reset_n;
   logic        sel;
   logic        en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [2:0]  wmode;
   logic        re;
   logic [2:0]  rmode;
   logic        a_en, b_en;
   logic [31:0] a_rd, b_rd;
   logic        a_wait, b_wait, a_fault, b_fault;
   logic [31:0] obs_rd;
   logic        obs_wait, obs_fault;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mdl [2][4096];
   logic [31:0] last_rd [2];

   assign a_en      = en & ~sel;
   assign b_en      = en & sel;
   assign obs_rd    = sel ? b_rd : a_rd;
   assign obs_wait  = sel ? b_wait : a_wait;
   assign obs_fault = sel ? b_fault : a_fault;

   dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .dmem_address(addr), .dmem_enable(a_en),
      .dmem_write_data(wdata), .dmem_write_enable(we), .dmem_write_mode(wmode),
      .dmem_read_enable(re), .dmem_read_mode(rmode), .dmem_read_data(a_rd),
      .dmem_wait(a_wait), .access_fault(a_fault));

   dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .dmem_address(addr), .dmem_enable(b_en),
      .dmem_write_data(wdata), .dmem_write_enable(we), .dmem_write_mode(wmode),
      .dmem_read_enable(re), .dmem_read_mode(rmode), .dmem_read_data(b_rd),
      .dmem_wait(b_wait), .access_fault(b_fault));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: memory as bytes, accesses as (offset, size) ranges.
   task automatic model_apply(input int s, input logic e, input logic [31:0] ad,
                              input logic [31:0] wd, input logic w, input logic [2:0] wm,
                              input logic r, input logic [2:0] rm,
                              output logic [31:0] exp_rd, output logic exp_f, output int exp_w);
      int a, rsz, wsz;
      logic rbad, wbad;
      logic [31:0] v;
      exp_f = 1'b0;
      exp_w = 0;
      if (e && (r || w)) begin
         exp_w = (s == 1) ? 3 : 0;
         a    = int'(ad[11:0]);
         rsz  = 1 << rm[1:0];
         wsz  = 1 << wm[1:0];
         rbad = (rm == 3'd3) || (rm == 3'd6) || (rm == 3'd7) || ((a % rsz) != 0);
         wbad = (wm > 3'd2) || ((a % wsz) != 0);
         if (r) begin
            if (rbad) begin
               last_rd[s] = 32'd0;
            end else begin
               v = 32'd0;
               for (int k = 0; k < rsz; k++) v = v | (32'(mdl[s][12'(a + k)]) << (8 * k));
               last_rd[s] = v;
            end
         end
         if (w && !wbad) begin
            for (int k = 0; k < wsz; k++) mdl[s][12'(a + k)] = wd[8*k +: 8];
         end
         exp_f = (r && rbad) || (w && wbad);
      end
      exp_rd = last_rd[s];
   endtask

   task automatic xact(input bit s, input logic e, input logic [31:0] ad, input logic [31:0] wd,
                       input logic w, input logic [2:0] wm, input logic r, input logic [2:0] rm,
                       output logic [31:0] got_rd, output logic got_f);
      logic [31:0] exp_rd;
      logic        exp_f;
      int          exp_w, nw;
      @(negedge clk);
      sel = s; en = e; addr = ad; wdata = wd; we = w; wmode = wm; re = r; rmode = rm;
      model_apply(int'(s), e, ad, wd, w, wm, r, rm, exp_rd, exp_f, exp_w);
      @(posedge clk); #1;
      nw = 0;
      while (obs_wait && nw < 20) begin
         nw++;
         addr  = $urandom;
         wdata = $urandom;
         @(posedge clk); #1;
      end
      check("wait_cycles", 32'(nw), 32'(exp_w));
      check("rdata", obs_rd, exp_rd);
      check("fault", 32'(obs_fault), 32'(exp_f));
      got_rd = obs_rd;
      got_f  = obs_fault;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      en = 1'b0; we = 1'b0; re = 1'b0;
      @(posedge clk); #1;
      check("idle_wait", 32'(obs_wait), 32'd0);
      check("idle_fault", 32'(obs_fault), 32'd0);
   endtask

   initial begin
      logic [31:0] rd, ra;
      logic        f, e, w, r;
      logic [2:0]  wm, rm;
      bit          s;
      reset_n = 1'b0; sel = 1'b0; en = 1'b0; addr = 32'd0; wdata = 32'd0;
      we = 1'b0; wmode = 3'd0; re = 1'b0; rmode = 3'd0;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_a_rd", a_rd, 32'd0);
      check("rst_a_wait", 32'(a_wait), 32'd0);
      check("rst_a_fault", 32'(a_fault), 32'd0);
      check("rst_b_rd", b_rd, 32'd0);
      check("rst_b_wait", 32'(b_wait), 32'd0);
      check("rst_b_fault", 32'(b_fault), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Give the model a known image of words 0x00..0x7C in both instances.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 32; i++)
            xact(d[0], 1'b1, 32'(i * 4), $urandom, 1'b1, 3'b010, 1'b0, 3'b000, rd, f);

      for (int d = 0; d < 2; d++) begin
         s = d[0];
         xact(s, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 3'b010, 1'b0, 3'b000, rd, f);
         xact(s, 1'b1, 32'h100, 32'd0, 1'b0, 3'b000, 1'b1, 3'b010, rd, f);
         check("plan_word_load", rd, 32'hDEADBEEF);
         xact(s, 1'b1, 32'h102, 32'h00000055, 1'b1, 3'b000, 1'b0, 3'b000, rd, f);
         xact(s, 1'b1, 32'h100, 32'd0, 1'b0, 3'b000, 1'b1, 3'b010, rd, f);
         check("plan_byte_merge", rd, 32'hDE55BEEF);
         xact(s, 1'b1, 32'h102, 32'd0, 1'b0, 3'b000, 1'b1, 3'b101, rd, f);
         check("plan_half_load", rd, 32'h0000DE55);
         xact(s, 1'b1, 32'h101, 32'h12345678, 1'b1, 3'b010, 1'b0, 3'b000, rd, f);
         check("plan_misaligned_store_fault", 32'(f), 32'd1);
         xact(s, 1'b1, 32'h100, 32'd0, 1'b0, 3'b000, 1'b1, 3'b010, rd, f);
         check("plan_word_unchanged", rd, 32'hDE55BEEF);
         xact(s, 1'b1, 32'h103, 32'd0, 1'b0, 3'b000, 1'b1, 3'b001, rd, f);
         check("plan_misaligned_half_data", rd, 32'd0);
         check("plan_misaligned_half_fault", 32'(f), 32'd1);
         idle_cycle();
         xact(s, 1'b1, 32'h00001004, 32'hA5A5A5A5, 1'b1, 3'b010, 1'b0, 3'b000, rd, f);
         xact(s, 1'b1, 32'h00000004, 32'd0, 1'b0, 3'b000, 1'b1, 3'b010, rd, f);
         check("plan_alias", rd, 32'hA5A5A5A5);
         idle_cycle();
      end

      // Reset in the middle of a stalled store on the wait-state instance.
      @(negedge clk);
      sel = 1'b1; en = 1'b1; addr = 32'h100; wdata = 32'h11112222;
      we = 1'b1; wmode = 3'b010; re = 1'b0; rmode = 3'b000;
      @(posedge clk); #1;
      check("rst_mid_wait_pre", 32'(b_wait), 32'd1);
      @(posedge clk); #1;
      #1 reset_n = 1'b0;
      #1;
      check("rst_mid_wait", 32'(b_wait), 32'd0);
      check("rst_mid_rd", b_rd, 32'd0);
      check("rst_mid_fault", 32'(b_fault), 32'd0);
      en = 1'b0; we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      xact(1'b1, 1'b1, 32'h100, 32'd0, 1'b0, 3'b000, 1'b1, 3'b010, rd, f);
      check("rst_store_dropped", rd, 32'hDE55BEEF);

      // Random mix of requests over the initialised window, with aliased upper bits.
      for (int i = 0; i < 200; i++) begin
         s  = 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 7) != 0);
         ra = $urandom & 32'hFFFF_F07F;
         if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
         w  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         wm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         rm = 3'($urandom_range(0, 7));
         xact(s, e, ra, $urandom, w, wm, r, rm, rd, f);
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
